// File: rtl/mvu_job_queue_pkg.sv
// Shared types for the MVU job queue: field widths matching mvutop, the packed job
// descriptor and the per-channel launch FSM states.
package mvu_jobq_pkg;

  localparam int unsigned BCNTDWN  = 29;
  localparam int unsigned BPREC    = 6;
  localparam int unsigned BBWADDR  = 9;
  localparam int unsigned BBDADDR  = 15;
  localparam int unsigned BSTRIDE  = 15;
  localparam int unsigned BLENGTH  = 15;
  localparam int unsigned BQMSBIDX = 5;

  typedef struct packed {
    logic [BQMSBIDX-1:0] quant_msbidx;
    logic [BCNTDWN-1:0]  countdown;
    logic [BPREC-1:0]    wprecision;
    logic [BPREC-1:0]    iprecision;
    logic [BPREC-1:0]    oprecision;
    logic [BBWADDR-1:0]  wbaseaddr;
    logic [BBDADDR-1:0]  ibaseaddr;
    logic [BBDADDR-1:0]  obaseaddr;
    logic [BSTRIDE-1:0]  wstride_0;
    logic [BSTRIDE-1:0]  wstride_1;
    logic [BSTRIDE-1:0]  wstride_2;
    logic [BSTRIDE-1:0]  istride_0;
    logic [BSTRIDE-1:0]  istride_1;
    logic [BSTRIDE-1:0]  istride_2;
    logic [BSTRIDE-1:0]  ostride_0;
    logic [BSTRIDE-1:0]  ostride_1;
    logic [BSTRIDE-1:0]  ostride_2;
    logic [BLENGTH-1:0]  wlength_0;
    logic [BLENGTH-1:0]  wlength_1;
    logic [BLENGTH-1:0]  wlength_2;
    logic [BLENGTH-1:0]  ilength_0;
    logic [BLENGTH-1:0]  ilength_1;
    logic [BLENGTH-1:0]  ilength_2;
    logic [BLENGTH-1:0]  olength_0;
    logic [BLENGTH-1:0]  olength_1;
    logic [BLENGTH-1:0]  olength_2;
  } mvu_job_t;

  localparam int unsigned JOBW = $bits(mvu_job_t);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStart,
    StRun
  } mvu_jobq_state_e;

endpackage

// File: rtl/mvu_job_queue_if.sv
// Job push handshake between a host/controller (master) and the job queue (slave).
interface mvu_job_queue_if #(
  parameter int unsigned NMVU = 1
);
  import mvu_jobq_pkg::*;

  localparam int unsigned BMVUA = (NMVU > 1) ? $clog2(NMVU) : 1;

  logic             job_valid;
  logic [BMVUA-1:0] job_mvu;
  logic [JOBW-1:0]  job_word;
  logic             job_ready;

  modport master (
    output job_valid,
    output job_mvu,
    output job_word,
    input  job_ready
  );

  modport slave (
    input  job_valid,
    input  job_mvu,
    input  job_word,
    output job_ready
  );

endinterface

// File: rtl/mvu_job_fifo.sv
// Single-clock job FIFO with one-cycle flush; pointers carry an extra wrap bit so that
// full and empty are distinguishable.
module mvu_job_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [CntW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[PtrW-1:0]];

  // A pop frees a slot in the same cycle, so a full queue may still accept a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    rd_d = rd_q + CntW'(do_pop);
    wr_d = flush_i ? rd_d : (wr_q + CntW'(do_push));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mvu_job_queue.sv
// Per-MVU job queue and launch sequencer: queues job descriptors, applies config,
// pulses start, waits for done and raises a sticky drain interrupt.
module mvu_job_queue
  import mvu_jobq_pkg::*;
#(
  parameter int unsigned NMVU  = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  mvu_job_queue_if.slave                    jif,
  input  logic [NMVU-1:0]                   q_flush,
  input  logic [NMVU-1:0]                   irq_clr,
  output logic [NMVU-1:0]                   start,
  input  logic [NMVU-1:0]                   done,
  output logic [NMVU*BCNTDWN-1:0]           countdown,
  output logic [NMVU*BPREC-1:0]             wprecision,
  output logic [NMVU*BPREC-1:0]             iprecision,
  output logic [NMVU*BPREC-1:0]             oprecision,
  output logic [NMVU*BBWADDR-1:0]           wbaseaddr,
  output logic [NMVU*BBDADDR-1:0]           ibaseaddr,
  output logic [NMVU*BBDADDR-1:0]           obaseaddr,
  output logic [NMVU*BSTRIDE-1:0]           wstride_0,
  output logic [NMVU*BSTRIDE-1:0]           wstride_1,
  output logic [NMVU*BSTRIDE-1:0]           wstride_2,
  output logic [NMVU*BSTRIDE-1:0]           istride_0,
  output logic [NMVU*BSTRIDE-1:0]           istride_1,
  output logic [NMVU*BSTRIDE-1:0]           istride_2,
  output logic [NMVU*BSTRIDE-1:0]           ostride_0,
  output logic [NMVU*BSTRIDE-1:0]           ostride_1,
  output logic [NMVU*BSTRIDE-1:0]           ostride_2,
  output logic [NMVU*BLENGTH-1:0]           wlength_0,
  output logic [NMVU*BLENGTH-1:0]           wlength_1,
  output logic [NMVU*BLENGTH-1:0]           wlength_2,
  output logic [NMVU*BLENGTH-1:0]           ilength_0,
  output logic [NMVU*BLENGTH-1:0]           ilength_1,
  output logic [NMVU*BLENGTH-1:0]           ilength_2,
  output logic [NMVU*BLENGTH-1:0]           olength_0,
  output logic [NMVU*BLENGTH-1:0]           olength_1,
  output logic [NMVU*BLENGTH-1:0]           olength_2,
  output logic [NMVU*BQMSBIDX-1:0]          quant_msbidx,
  output logic [NMVU-1:0]                   busy,
  output logic [NMVU*($clog2(DEPTH)+1)-1:0] q_level,
  output logic [NMVU-1:0]                   irq
);

  localparam int unsigned BMVUA = (NMVU > 1) ? $clog2(NMVU) : 1;
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1;

  logic [NMVU-1:0] full;

  // Out-of-range channel indices never match, so they see job_ready = 0.
  always_comb begin
    jif.job_ready = 1'b0;
    for (int unsigned m = 0; m < NMVU; m++) begin
      if (jif.job_mvu == BMVUA'(m)) begin
        jif.job_ready = !full[m];
      end
    end
  end

  for (genvar m = 0; m < NMVU; m++) begin : g_ch
    mvu_jobq_state_e state_q, state_d;
    mvu_job_t        cfg_q, cfg_d;
    logic            first_q, first_d;
    logic            irq_q, irq_d;
    logic            push, pop, complete, empty;
    logic [JOBW-1:0] rdata;
    logic [LvlW-1:0] level, level_after_pop;

    assign push = jif.job_valid && jif.job_ready && (jif.job_mvu == BMVUA'(m));

    mvu_job_fifo #(
      .Width (JOBW),
      .Depth (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (q_flush[m]),
      .wdata_i (jif.job_word),
      .rdata_o (rdata),
      .full_o  (full[m]),
      .empty_o (empty),
      .level_o (level)
    );

    always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      first_d  = 1'b0;
      pop      = 1'b0;
      complete = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StLoad;
          end
        end
        StLoad:  state_d = StStart;
        StStart: begin
          state_d = StRun;
          first_d = 1'b1;
        end
        StRun: begin
          // first_q masks a done left over from the previous job
          if (!first_q && done[m]) begin
            complete = 1'b1;
            if (!empty) begin
              pop     = 1'b1;
              state_d = StLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
      if (pop) begin
        cfg_d = mvu_job_t'(rdata);
      end
    end

    assign level_after_pop = level - LvlW'(pop);

    always_comb begin
      irq_d = irq_q;
      if (irq_clr[m]) begin
        irq_d = 1'b0;
      end
      if (complete && (q_flush[m] || (level_after_pop == '0))) begin
        irq_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        cfg_q   <= '0;
        first_q <= 1'b0;
        irq_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cfg_q   <= cfg_d;
        first_q <= first_d;
        irq_q   <= irq_d;
      end
    end

    assign start[m]                   = (state_q == StStart);
    assign busy[m]                    = (state_q != StIdle);
    assign irq[m]                     = irq_q;
    assign q_level[m*LvlW +: LvlW]    = level;

    assign countdown[m*BCNTDWN +: BCNTDWN]      = cfg_q.countdown;
    assign wprecision[m*BPREC +: BPREC]         = cfg_q.wprecision;
    assign iprecision[m*BPREC +: BPREC]         = cfg_q.iprecision;
    assign oprecision[m*BPREC +: BPREC]         = cfg_q.oprecision;
    assign wbaseaddr[m*BBWADDR +: BBWADDR]      = cfg_q.wbaseaddr;
    assign ibaseaddr[m*BBDADDR +: BBDADDR]      = cfg_q.ibaseaddr;
    assign obaseaddr[m*BBDADDR +: BBDADDR]      = cfg_q.obaseaddr;
    assign wstride_0[m*BSTRIDE +: BSTRIDE]      = cfg_q.wstride_0;
    assign wstride_1[m*BSTRIDE +: BSTRIDE]      = cfg_q.wstride_1;
    assign wstride_2[m*BSTRIDE +: BSTRIDE]      = cfg_q.wstride_2;
    assign istride_0[m*BSTRIDE +: BSTRIDE]      = cfg_q.istride_0;
    assign istride_1[m*BSTRIDE +: BSTRIDE]      = cfg_q.istride_1;
    assign istride_2[m*BSTRIDE +: BSTRIDE]      = cfg_q.istride_2;
    assign ostride_0[m*BSTRIDE +: BSTRIDE]      = cfg_q.ostride_0;
    assign ostride_1[m*BSTRIDE +: BSTRIDE]      = cfg_q.ostride_1;
    assign ostride_2[m*BSTRIDE +: BSTRIDE]      = cfg_q.ostride_2;
    assign wlength_0[m*BLENGTH +: BLENGTH]      = cfg_q.wlength_0;
    assign wlength_1[m*BLENGTH +: BLENGTH]      = cfg_q.wlength_1;
    assign wlength_2[m*BLENGTH +: BLENGTH]      = cfg_q.wlength_2;
    assign ilength_0[m*BLENGTH +: BLENGTH]      = cfg_q.ilength_0;
    assign ilength_1[m*BLENGTH +: BLENGTH]      = cfg_q.ilength_1;
    assign ilength_2[m*BLENGTH +: BLENGTH]      = cfg_q.ilength_2;
    assign olength_0[m*BLENGTH +: BLENGTH]      = cfg_q.olength_0;
    assign olength_1[m*BLENGTH +: BLENGTH]      = cfg_q.olength_1;
    assign olength_2[m*BLENGTH +: BLENGTH]      = cfg_q.olength_2;
    assign quant_msbidx[m*BQMSBIDX +: BQMSBIDX] = cfg_q.quant_msbidx;
  end

endmodule

// File: tb/tb_mvu_job_queue.sv
// Randomized scoreboard bench for mvu_job_queue with two channels and four-deep queues.
module tb_mvu_job_queue;
  import mvu_jobq_pkg::*;

  localparam int unsigned NM = 2;
  localparam int unsigned LW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mvu_job_queue_if #(.NMVU(NM)) jif ();

  logic [NM-1:0] q_flush, irq_clr, start, busy, irq;
  logic          done_r [NM];
  wire  [NM-1:0] done = {done_r[1], done_r[0]};
  logic [NM*BCNTDWN-1:0]  countdown;
  logic [NM*BPREC-1:0]    wprecision, iprecision, oprecision;
  logic [NM*BBWADDR-1:0]  wbaseaddr;
  logic [NM*BBDADDR-1:0]  ibaseaddr, obaseaddr;
  logic [NM*BSTRIDE-1:0]  wstride_0, wstride_1, wstride_2, istride_0, istride_1, istride_2;
  logic [NM*BSTRIDE-1:0]  ostride_0, ostride_1, ostride_2;
  logic [NM*BLENGTH-1:0]  wlength_0, wlength_1, wlength_2, ilength_0, ilength_1, ilength_2;
  logic [NM*BLENGTH-1:0]  olength_0, olength_1, olength_2;
  logic [NM*BQMSBIDX-1:0] quant_msbidx;
  logic [NM*LW-1:0]       q_level;

  mvu_job_queue #(.NMVU(NM), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .jif(jif), .q_flush(q_flush), .irq_clr(irq_clr),
    .start(start), .done(done), .countdown(countdown), .wprecision(wprecision),
    .iprecision(iprecision), .oprecision(oprecision), .wbaseaddr(wbaseaddr),
    .ibaseaddr(ibaseaddr), .obaseaddr(obaseaddr), .wstride_0(wstride_0),
    .wstride_1(wstride_1), .wstride_2(wstride_2), .istride_0(istride_0),
    .istride_1(istride_1), .istride_2(istride_2), .ostride_0(ostride_0),
    .ostride_1(ostride_1), .ostride_2(ostride_2), .wlength_0(wlength_0),
    .wlength_1(wlength_1), .wlength_2(wlength_2), .ilength_0(ilength_0),
    .ilength_1(ilength_1), .ilength_2(ilength_2), .olength_0(olength_0),
    .olength_1(olength_1), .olength_2(olength_2), .quant_msbidx(quant_msbidx),
    .busy(busy), .q_level(q_level), .irq(irq)
  );

  int        n_tests = 0;
  int        n_fail = 0;
  mvu_job_t  sb [NM][$];
  int        run_len [NM];
  bit        stale [NM];
  int        start_cnt [NM];
  logic      start_prev [NM];
  mvu_job_t  prev_cfg [NM];
  mvu_job_t  cur_cfg, exp_job;
  bit        both_busy = 1'b0;

  task automatic check_job(input string nm, input mvu_job_t got, input mvu_job_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic mvu_job_t get_cfg(input int m);
    mvu_job_t j;
    j.quant_msbidx = quant_msbidx[m*BQMSBIDX +: BQMSBIDX];
    j.countdown    = countdown[m*BCNTDWN +: BCNTDWN];
    j.wprecision   = wprecision[m*BPREC +: BPREC];
    j.iprecision   = iprecision[m*BPREC +: BPREC];
    j.oprecision   = oprecision[m*BPREC +: BPREC];
    j.wbaseaddr    = wbaseaddr[m*BBWADDR +: BBWADDR];
    j.ibaseaddr    = ibaseaddr[m*BBDADDR +: BBDADDR];
    j.obaseaddr    = obaseaddr[m*BBDADDR +: BBDADDR];
    j.wstride_0    = wstride_0[m*BSTRIDE +: BSTRIDE];
    j.wstride_1    = wstride_1[m*BSTRIDE +: BSTRIDE];
    j.wstride_2    = wstride_2[m*BSTRIDE +: BSTRIDE];
    j.istride_0    = istride_0[m*BSTRIDE +: BSTRIDE];
    j.istride_1    = istride_1[m*BSTRIDE +: BSTRIDE];
    j.istride_2    = istride_2[m*BSTRIDE +: BSTRIDE];
    j.ostride_0    = ostride_0[m*BSTRIDE +: BSTRIDE];
    j.ostride_1    = ostride_1[m*BSTRIDE +: BSTRIDE];
    j.ostride_2    = ostride_2[m*BSTRIDE +: BSTRIDE];
    j.wlength_0    = wlength_0[m*BLENGTH +: BLENGTH];
    j.wlength_1    = wlength_1[m*BLENGTH +: BLENGTH];
    j.wlength_2    = wlength_2[m*BLENGTH +: BLENGTH];
    j.ilength_0    = ilength_0[m*BLENGTH +: BLENGTH];
    j.ilength_1    = ilength_1[m*BLENGTH +: BLENGTH];
    j.ilength_2    = ilength_2[m*BLENGTH +: BLENGTH];
    j.olength_0    = olength_0[m*BLENGTH +: BLENGTH];
    j.olength_1    = olength_1[m*BLENGTH +: BLENGTH];
    j.olength_2    = olength_2[m*BLENGTH +: BLENGTH];
    return j;
  endfunction

  function automatic mvu_job_t rand_job();
    logic [JOBW-1:0] v;
    for (int i = 0; i < int'(JOBW); i++) v[i] = (($urandom % 2) != 0);
    return mvu_job_t'(v);
  endfunction

  function automatic int lvl(input int m);
    return int'(q_level[m*LW +: LW]);
  endfunction

  // Behavioural mvutop: done pulses run_len cycles after a start pulse.
  task automatic done_model(input int m);
    forever begin
      @(negedge clk);
      if (start[m] && !stale[m]) begin
        repeat (run_len[m]) @(negedge clk);
        done_r[m] = 1'b1;
        @(negedge clk);
        done_r[m] = 1'b0;
      end
    end
  endtask

  // Scoreboard monitor: every launch must carry the oldest outstanding job of its channel.
  always @(negedge clk) begin
    for (int m = 0; m < int'(NM); m++) begin
      cur_cfg = get_cfg(m);
      if (rst_n && start[m]) begin
        start_cnt[m]++;
        check_int("start_width", int'(start_prev[m]), 0);
        if (sb[m].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start ch%0d: got start=1 expected no launch", m);
        end else begin
          exp_job = sb[m].pop_front();
          check_job("cfg_at_start", cur_cfg, exp_job);
          check_job("cfg_before_start", prev_cfg[m], exp_job);
        end
      end
      start_prev[m] = start[m];
      prev_cfg[m]   = cur_cfg;
    end
    if (busy == 2'b11) both_busy = 1'b1;
  end

  task automatic push_job(input int m, input mvu_job_t j, output bit acc);
    @(negedge clk);
    jif.job_valid = 1'b1;
    jif.job_mvu   = 1'(m);
    jif.job_word  = j;
    #1;
    acc = jif.job_ready;
    if (acc) sb[m].push_back(j);
    @(posedge clk);
    #1 jif.job_valid = 1'b0;
  endtask

  task automatic wait_start(input int m, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!start[m] && cyc < limit);
    if (!start[m]) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_timeout ch%0d: got no start in %0d cycles expected a launch", m, limit);
    end
  endtask

  task automatic wait_idle(input int m, input int limit);
    int c;
    c = 0;
    while (busy[m] && c < limit) begin
      @(negedge clk);
      c++;
    end
    check_int("idle_in_time", int'(busy[m]), 0);
  endtask

  task automatic pulse_clr(input int m);
    @(negedge clk);
    irq_clr[m] = 1'b1;
    @(negedge clk);
    irq_clr[m] = 1'b0;
  endtask

  initial begin
    bit       acc, found;
    int       cyc, m, sc;
    mvu_job_t j;
    jif.job_valid = 1'b0;
    jif.job_mvu   = '0;
    jif.job_word  = '0;
    q_flush = '0;
    irq_clr = '0;
    for (int i = 0; i < int'(NM); i++) begin
      done_r[i] = 1'b0; stale[i] = 1'b0; run_len[i] = 16; start_cnt[i] = 0;
    end
    fork
      done_model(0);
      done_model(1);
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_int("rst_start", int'(start), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_irq", int'(irq), 0);
    check_int("rst_qlevel", int'(q_level), 0);
    check_int("rst_ready", int'(jif.job_ready), 1);
    check_job("rst_cfg", get_cfg(0), '0);
    rst_n = 1'b1;

    // Single job: launch latency and drain interrupt
    j = rand_job();
    j.wprecision = 6'd2;
    j.countdown  = 29'd16;
    j.obaseaddr  = 15'h4000;
    run_len[0] = 16;
    push_job(0, j, acc);
    check_int("push_acc_single", int'(acc), 1);
    @(negedge clk); check_int("lat_t0_start", int'(start[0]), 0);
    check_int("lat_t0_busy", int'(busy[0]), 0);
    @(negedge clk); check_int("lat_load_start", int'(start[0]), 0);
    check_int("lat_load_busy", int'(busy[0]), 1);
    @(negedge clk); check_int("lat_start_high", int'(start[0]), 1);
    @(negedge clk); check_int("lat_start_low", int'(start[0]), 0);
    check_int("irq_before_done", int'(irq[0]), 0);
    wait_idle(0, 40);
    check_int("irq_after_done", int'(irq[0]), 1);
    pulse_clr(0);
    check_int("irq_cleared", int'(irq[0]), 0);

    // Fill the queue behind a running job, overflow, then watch FIFO-order launches
    run_len[0] = 40;
    push_job(0, rand_job(), acc);
    wait_start(0, 10, cyc);
    run_len[0] = 5;
    for (int k = 0; k < 4; k++) begin
      push_job(0, rand_job(), acc);
      check_int("push_acc_fill", int'(acc), 1);
    end
    @(negedge clk);
    check_int("ready_full", int'(jif.job_ready), 0);
    check_int("level_full", lvl(0), 4);
    push_job(0, rand_job(), acc);
    check_int("push_full_ignored", int'(acc), 0);
    @(negedge clk);
    check_int("level_after_overflow", lvl(0), 4);
    for (int k = 0; k < 4; k++) begin
      wait_start(0, 60, cyc);
      check_int("level_step", lvl(0), 3 - k);
      if (k > 0) check_int("issue_gap", cyc, 7);
    end
    wait_idle(0, 40);
    pulse_clr(0);

    // Stale done held high across the launch
    stale[0] = 1'b1;
    done_r[0] = 1'b1;
    push_job(0, rand_job(), acc);
    wait_start(0, 10, cyc);
    @(negedge clk); check_int("stale_run1_busy", int'(busy[0]), 1);
    @(negedge clk); check_int("stale_run2_busy", int'(busy[0]), 1);
    @(negedge clk); check_int("stale_done_busy", int'(busy[0]), 0);
    done_r[0] = 1'b0;
    stale[0] = 1'b0;
    pulse_clr(0);

    // Randomized interleaved traffic on both channels
    for (int it = 0; it < 80; it++) begin
      m = int'($urandom_range(0, 1));
      run_len[m] = int'($urandom_range(2, 8));
      if ($urandom_range(0, 3) != 0) push_job(m, rand_job(), acc);
      else @(negedge clk);
    end
    sc = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || busy != 0) && sc < 3000) begin
      @(negedge clk);
      sc++;
    end
    check_int("drain_sb0", sb[0].size(), 0);
    check_int("drain_sb1", sb[1].size(), 0);
    check_int("drain_busy", int'(busy), 0);
    check_int("channels_concurrent", int'(both_busy), 1);
    pulse_clr(0);
    pulse_clr(1);

    // Flush three queued jobs while one runs; a coincident push is dropped
    run_len[0] = 20;
    push_job(0, rand_job(), acc);
    wait_start(0, 10, cyc);
    for (int k = 0; k < 3; k++) push_job(0, rand_job(), acc);
    @(negedge clk);
    check_int("level_before_flush", lvl(0), 3);
    #1;
    q_flush[0] = 1'b1;
    jif.job_valid = 1'b1;
    jif.job_mvu = 1'b0;
    jif.job_word = rand_job();
    @(posedge clk);
    #1;
    q_flush[0] = 1'b0;
    jif.job_valid = 1'b0;
    sb[0].delete();
    @(negedge clk);
    check_int("level_after_flush", lvl(0), 0);
    check_int("busy_after_flush", int'(busy[0]), 1);
    wait_idle(0, 40);
    sc = start_cnt[0];
    repeat (20) @(negedge clk);
    check_int("no_start_after_flush", start_cnt[0] - sc, 0);
    pulse_clr(0);

    // irq_clr coinciding with a completion: set wins
    run_len[0] = 4;
    push_job(0, rand_job(), acc);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done_r[0]) begin
        found = 1'b1;
        break;
      end
    end
    check_int("done_seen", int'(found), 1);
    check_int("irq_before_coincide", int'(irq[0]), 0);
    irq_clr[0] = 1'b1;
    @(negedge clk);
    irq_clr[0] = 1'b0;
    check_int("irq_set_wins", int'(irq[0]), 1);

    // Asynchronous reset in the middle of a run
    run_len[0] = 20;
    push_job(0, rand_job(), acc);
    wait_start(0, 10, cyc);
    repeat (3) @(negedge clk);
    check_int("pre_rst_busy", int'(busy[0]), 1);
    check_int("pre_rst_irq", int'(irq[0]), 1);
    rst_n = 1'b0;
    #1;
    check_int("midrst_start", int'(start), 0);
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_irq", int'(irq), 0);
    check_int("midrst_level", int'(q_level), 0);
    check_job("midrst_cfg", get_cfg(0), '0);
    @(negedge clk);
    rst_n = 1'b1;
    sc = start_cnt[0];
    repeat (30) @(negedge clk);
    check_int("no_start_after_rst", start_cnt[0] - sc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
